alu_seq: RTL
============

# alu_seq

Microsequencer that runs one ALU operation at a time over the shared 16-bit processor bus. It takes a request (opcode, two source registers, optional destination) and sequences the register-file out/in enables, Y latch, Z latch and Z drive in the required order. It arbitrates for the bus through a req/gnt pair, because the bus is shared with the memory/fetch path. It sits between the instruction decoder and the register file / Y / ALU / Z datapath.

## Interface
- NREG, 8, number of general registers (one-hot enable width)
- RW, 3, register index width (clog2(NREG))
- OPW, 4, ALU opcode width
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = in reset); one clock; reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted on the rising edge where req_valid & req_ready
- req_op  in  OPW  ALU opcode
- req_src_a  in  RW  first operand register (latched into Y)
- req_src_b  in  RW  second operand register (driven to bus during execute)
- req_dst  in  RW  destination register
- req_unary  in  1  1 = skip Y load; ALU uses bus operand only
- req_wb  in  1  1 = write result to req_dst; 0 = result stays in Z only
- bus_req  out  1  sequencer wants the bus this cycle
- bus_gnt  in  1  bus granted this cycle
- reg_out  out  NREG  one-hot register-to-bus drive enable
- reg_in  out  NREG  one-hot bus-to-register latch enable
- Y_in  out  1  latch bus into Y
- Z_in  out  1  latch ALU result into Z
- Z_out  out  1  drive Z onto bus
- alu_op  out  OPW  opcode presented to the ALU
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, operation complete

## Operation
- States: IDLE, LOAD_Y, EXEC, WRITE.
- IDLE: req_ready=1; on accept, capture op/src/dst/unary/wb into an active register; next state EXEC if unary, else LOAD_Y.
- LOAD_Y: reg_out[src_a]=1, Y_in=1; advance to EXEC.
- EXEC: reg_out[src_b]=1, alu_op=op, Z_in=1; advance to WRITE if wb, else complete.
- WRITE: Z_out=1, reg_in[dst]=1, Z_in=0 (Z drives its primary copy); complete.
- bus_req=1 in LOAD_Y, EXEC and WRITE. A phase's enables (reg_out, reg_in, Y_in, Z_in, Z_out) are asserted only in cycles with bus_gnt=1. The state advances only on a granted cycle. With gnt low, the state holds, all enables are 0, and bus_req stays 1.
- alu_op holds the active opcode whenever busy; it is 0 in IDLE.
- Complete: done=1 in the next cycle (registered), then return to IDLE (or to the buffered request, see Configuration).
- reg_out and reg_in are never both nonzero in the same cycle. At most one bit of each is set.

## Timing
- Reset (async assert): state=IDLE; all enables, bus_req, busy, done and alu_op = 0 immediately. Active and buffer registers are cleared. A mid-operation reset aborts with no done. req_ready reads 1 once reset deasserts.
- Latency with continuous grant, measured from the accept edge t:
  - binary + wb: LOAD_Y t+1, EXEC t+2, WRITE t+3, done t+4.
  - unary without wb: EXEC t+1, done t+2.
- Each cycle of bus_gnt=0 inside a phase adds exactly one cycle.
- req fields are sampled only on the accept edge; later changes have no effect.
- A Z_in followed by Z_out always has at least one cycle between them, so Z_out returns the newly latched result.

## Configuration
- ALU_SEQ_BUF_EN defined:
  - Adds a one-deep request buffer. req_ready = !buf_full, so a request can be accepted while busy.
  - On completion with the buffer full, the next state is LOAD_Y (or EXEC if unary) directly, with no IDLE cycle. done pulses concurrently with that first phase.
  - Accept and complete on the same edge is legal: the buffer is refilled.
- ALU_SEQ_BUF_EN undefined: req_ready = (state==IDLE). No buffer logic exists.

## Test plan
- Reset release, then request op=4'h2, src_a=1, src_b=2, dst=3, wb=1, gnt=1 -> reg_out=8'h02+Y_in, then 8'h04+Z_in+alu_op=2, then Z_out+reg_in=8'h08, then done; 4 cycles after accept.
- Unary op=4'h7, src_b=5, wb=0 -> single EXEC cycle (reg_out=8'h20, Z_in); done at t+2; no Z_out or reg_in ever asserted.
- bus_gnt held 0 for 3 cycles during EXEC -> bus_req=1, enables 0, state held; completion delayed by exactly 3 cycles.
- Assert reset low during WRITE -> Z_out and reg_in drop asynchronously; no done pulse; next request runs normally.
- Two back-to-back requests (A binary wb, B unary wb):
  - With ALU_SEQ_BUF_EN: B is accepted while A is busy, and B's EXEC immediately follows A's WRITE.
  - Without it: req_ready=0 until IDLE, and there is one IDLE cycle between A and B.
- Random request/grant stream against a reference model -> reg_out/reg_in never both nonzero, one-hot held, done count equals accept count.

Source files
------------

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - single-operation ALU microsequencer with bus req/gnt; optional request buffer via ALU_SEQ_BUF_EN
module alu_seq #(
    parameter int NREG = 8,
    parameter int RW   = 3,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OPW-1:0]  req_op,
    input  logic [RW-1:0]   req_src_a,
    input  logic [RW-1:0]   req_src_b,
    input  logic [RW-1:0]   req_dst,
    input  logic            req_unary,
    input  logic            req_wb,
    output logic            bus_req,
    input  logic            bus_gnt,
    output logic [NREG-1:0] reg_out,
    output logic [NREG-1:0] reg_in,
    output logic            Y_in,
    output logic            Z_in,
    output logic            Z_out,
    output logic [OPW-1:0]  alu_op,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_Y = 2'd1,
        EXEC   = 2'd2,
        WRITE  = 2'd3
    } state_t;

    state_t          state_q, state_d;

    // Active operation, captured when a request is launched
    logic [OPW-1:0]  op_q, op_d;
    logic [RW-1:0]   src_a_q, src_a_d;
    logic [RW-1:0]   src_b_q, src_b_d;
    logic [RW-1:0]   dst_q, dst_d;
    logic            unary_q, unary_d;
    logic            wb_q, wb_d;

    // Registered outputs; phase enables are later gated by bus_gnt
    logic            done_q, done_d;
    logic            bus_req_q, bus_req_d;
    logic            busy_q, busy_d;
    logic [OPW-1:0]  alu_op_q, alu_op_d;
    logic [NREG-1:0] ph_out_q, ph_out_d;
    logic [NREG-1:0] ph_in_q, ph_in_d;
    logic            ph_y_q, ph_y_d;
    logic            ph_zin_q, ph_zin_d;
    logic            ph_zout_q, ph_zout_d;

    // Launch source selection (direct request or buffered request)
    logic            accept;
    logic            complete;
    logic            launch;
    logic [OPW-1:0]  l_op;
    logic [RW-1:0]   l_src_a;
    logic [RW-1:0]   l_src_b;
    logic [RW-1:0]   l_dst;
    logic            l_unary;
    logic            l_wb;

`ifdef ALU_SEQ_BUF_EN
    logic            buf_full_q, buf_full_d;
    logic [OPW-1:0]  buf_op_q, buf_op_d;
    logic [RW-1:0]   buf_src_a_q, buf_src_a_d;
    logic [RW-1:0]   buf_src_b_q, buf_src_b_d;
    logic [RW-1:0]   buf_dst_q, buf_dst_d;
    logic            buf_unary_q, buf_unary_d;
    logic            buf_wb_q, buf_wb_d;

    assign req_ready = !buf_full_q;
`else
    assign req_ready = (state_q == IDLE);
`endif

    function automatic logic [NREG-1:0] onehot(input logic [RW-1:0] idx);
        onehot = {{(NREG-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Next-state, operation capture and registered-output decode
    always_comb begin
        accept    = req_valid & req_ready;
        complete  = 1'b0;
        launch    = 1'b0;
        l_op      = req_op;
        l_src_a   = req_src_a;
        l_src_b   = req_src_b;
        l_dst     = req_dst;
        l_unary   = req_unary;
        l_wb      = req_wb;
        state_d   = state_q;
        op_d      = op_q;
        src_a_d   = src_a_q;
        src_b_d   = src_b_q;
        dst_d     = dst_q;
        unary_d   = unary_q;
        wb_d      = wb_q;

        case (state_q)
            IDLE:    launch = accept;
            LOAD_Y:  if (bus_gnt) state_d = EXEC;
            EXEC: begin
                if (bus_gnt) begin
                    if (wb_q) state_d = WRITE;
                    else      complete = 1'b1;
                end
            end
            WRITE:   if (bus_gnt) complete = 1'b1;
            default: state_d = IDLE;
        endcase

        if (complete) state_d = IDLE;

`ifdef ALU_SEQ_BUF_EN
        buf_full_d  = buf_full_q;
        buf_op_d    = buf_op_q;
        buf_src_a_d = buf_src_a_q;
        buf_src_b_d = buf_src_b_q;
        buf_dst_d   = buf_dst_q;
        buf_unary_d = buf_unary_q;
        buf_wb_d    = buf_wb_q;
        if (complete) begin
            if (buf_full_q) begin
                // Chain straight into the buffered request; refill if a new one arrives now
                launch     = 1'b1;
                l_op       = buf_op_q;
                l_src_a    = buf_src_a_q;
                l_src_b    = buf_src_b_q;
                l_dst      = buf_dst_q;
                l_unary    = buf_unary_q;
                l_wb       = buf_wb_q;
                buf_full_d = accept;
            end else begin
                launch = accept;
            end
        end
        if (accept && (state_q != IDLE) && (buf_full_q || !complete)) begin
            buf_full_d  = 1'b1;
            buf_op_d    = req_op;
            buf_src_a_d = req_src_a;
            buf_src_b_d = req_src_b;
            buf_dst_d   = req_dst;
            buf_unary_d = req_unary;
            buf_wb_d    = req_wb;
        end
`endif

        if (launch) begin
            op_d    = l_op;
            src_a_d = l_src_a;
            src_b_d = l_src_b;
            dst_d   = l_dst;
            unary_d = l_unary;
            wb_d    = l_wb;
            state_d = l_unary ? EXEC : LOAD_Y;
        end

        done_d    = complete;
        busy_d    = (state_d != IDLE);
        bus_req_d = (state_d != IDLE);
        alu_op_d  = busy_d ? op_d : '0;
        ph_out_d  = (state_d == LOAD_Y) ? onehot(src_a_d) :
                    (state_d == EXEC)   ? onehot(src_b_d) : '0;
        ph_in_d   = (state_d == WRITE)  ? onehot(dst_d) : '0;
        ph_y_d    = (state_d == LOAD_Y);
        ph_zin_d  = (state_d == EXEC);
        ph_zout_d = (state_d == WRITE);
    end

    // Sequencer state and registered outputs; reset aborts any operation silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            unary_q     <= 1'b0;
            wb_q        <= 1'b0;
            done_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            alu_op_q    <= '0;
            ph_out_q    <= '0;
            ph_in_q     <= '0;
            ph_y_q      <= 1'b0;
            ph_zin_q    <= 1'b0;
            ph_zout_q   <= 1'b0;
`ifdef ALU_SEQ_BUF_EN
            buf_full_q  <= 1'b0;
            buf_op_q    <= '0;
            buf_src_a_q <= '0;
            buf_src_b_q <= '0;
            buf_dst_q   <= '0;
            buf_unary_q <= 1'b0;
            buf_wb_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            dst_q       <= dst_d;
            unary_q     <= unary_d;
            wb_q        <= wb_d;
            done_q      <= done_d;
            bus_req_q   <= bus_req_d;
            busy_q      <= busy_d;
            alu_op_q    <= alu_op_d;
            ph_out_q    <= ph_out_d;
            ph_in_q     <= ph_in_d;
            ph_y_q      <= ph_y_d;
            ph_zin_q    <= ph_zin_d;
            ph_zout_q   <= ph_zout_d;
`ifdef ALU_SEQ_BUF_EN
            buf_full_q  <= buf_full_d;
            buf_op_q    <= buf_op_d;
            buf_src_a_q <= buf_src_a_d;
            buf_src_b_q <= buf_src_b_d;
            buf_dst_q   <= buf_dst_d;
            buf_unary_q <= buf_unary_d;
            buf_wb_q    <= buf_wb_d;
`endif
        end
    end

    // Datapath enables only fire in granted cycles
    assign reg_out = bus_gnt ? ph_out_q : '0;
    assign reg_in  = bus_gnt ? ph_in_q  : '0;
    assign Y_in    = bus_gnt & ph_y_q;
    assign Z_in    = bus_gnt & ph_zin_q;
    assign Z_out   = bus_gnt & ph_zout_q;
    assign bus_req = bus_req_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign alu_op  = alu_op_q;

endmodule
